// File: rtl/lobster_pkg.sv
// Shared types and constants for the instruction fetch unit.
package lobster_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} fetch_state_t;

  localparam int BUNDLE_BYTES = 8;
  localparam int BUNDLE_BITS  = BUNDLE_BYTES * 8;
  localparam logic [35:0] RESET_PC_DEFAULT = 36'hF800;
endpackage

// File: rtl/lobster_if.sv
// Memory, redirect and execution-manager signals of the fetch unit.
interface lobster_if import lobster_pkg::*; #(
  parameter int ADDR_WIDTH = 36
);
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_ack;
  logic [BUNDLE_BITS-1:0] mem_data;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [BUNDLE_BITS-1:0] out_data;
  logic [ADDR_WIDTH-1:0]  out_addr;
  logic [ADDR_WIDTH-1:0]  ip_out;

  modport master (
    output mem_req, mem_addr, out_valid, out_data, out_addr, ip_out,
    input  mem_ack, mem_data, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  mem_req, mem_addr, out_valid, out_data, out_addr, ip_out,
    output mem_ack, mem_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/lobster_fifo.sv
// Synchronous prefetch FIFO with flush; push when full and pop when empty are ignored.
module lobster_fifo #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/lobster_fetch.sv
// Instruction fetch: one outstanding bundle request, prefetch buffer, redirect flush.
module lobster_fetch import lobster_pkg::*; #(
  parameter int ADDR_WIDTH = 36,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input logic       clk,
  input logic       rst,
  lobster_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(BUNDLE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN   = ~ADDR_WIDTH'(BUNDLE_BYTES - 1);

  fetch_state_t                      state;
  logic [ADDR_WIDTH-1:0]             fetch_pc;
  logic [CW-1:0]                     count, cnt_after;
  logic                              push, pop;
  logic [ADDR_WIDTH+BUNDLE_BITS-1:0] head;

  // Redirect suppresses both FIFO ports; the flush wins regardless.
  assign push      = (state == REQ) && bus.mem_ack && !bus.redirect && (count < DEPTH_C);
  assign pop       = bus.out_valid && bus.out_ready && !bus.redirect;
  assign cnt_after = count + CW'(push) - CW'(pop);

  lobster_fifo #(.WIDTH(ADDR_WIDTH + BUNDLE_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata ({bus.mem_addr, bus.mem_data}),
    .rdata (head),
    .count (count)
  );

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = head[BUNDLE_BITS-1:0];
  assign bus.out_addr  = head[ADDR_WIDTH+BUNDLE_BITS-1:BUNDLE_BITS];
  assign bus.ip_out    = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ALIGN;
      // A request in flight cannot be cancelled; wait out its ack in FLUSH.
      case (state)
        REQ: begin
          state       <= bus.mem_ack ? IDLE : FLUSH;
          bus.mem_req <= !bus.mem_ack;
        end
        FLUSH: if (bus.mem_ack) begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
        end
        default: ;
      endcase
    end else begin
      case (state)
        IDLE: if (count < DEPTH_C) begin
          state        <= REQ;
          bus.mem_req  <= 1'b1;
          bus.mem_addr <= fetch_pc;
        end
        REQ: if (bus.mem_ack) begin
          fetch_pc <= bus.mem_addr + STEP;
          if (cnt_after < DEPTH_C) begin
            bus.mem_addr <= bus.mem_addr + STEP;
          end else begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
          end
        end
        FLUSH: if (bus.mem_ack) begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lobster_fetch.sv
// Directed bench for lobster_fetch: fill/drain table plus reset, redirect and wrap sequences.
module tb_lobster_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;

  lobster_if #(.ADDR_WIDTH(36)) bus ();

  lobster_fetch #(.ADDR_WIDTH(36), .FIFO_DEPTH(4), .RESET_PC(36'hF800)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rdy;
    logic        ack;
    logic [63:0] data;
    logic        req;
    logic [35:0] addr;
    logic        vld;
    logic [63:0] odata;
    logic [35:0] oaddr;
    logic [35:0] ip;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic ack, input logic [63:0] data,
                       input logic redir, input logic [35:0] rpc);
    bus.out_ready   = rdy;
    bus.mem_ack     = ack;
    bus.mem_data    = data;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  // Address and head data are only compared where they are defined.
  task automatic expect_out(input string tag, input logic req, input logic [35:0] addr,
                            input logic vld, input logic [63:0] odata,
                            input logic [35:0] oaddr, input logic [35:0] ip);
    chk({tag, ".mem_req"}, 64'(bus.mem_req), 64'(req));
    if (req) chk({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'(addr));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(vld));
    if (vld) begin
      chk({tag, ".out_data"}, bus.out_data, odata);
      chk({tag, ".out_addr"}, 64'(bus.out_addr), 64'(oaddr));
    end
    chk({tag, ".ip_out"}, 64'(bus.ip_out), 64'(ip));
  endtask

  initial begin
    // rdy ack data | req addr vld odata oaddr ip
    tbl[0]  = '{1'b0, 1'b0, 64'h0,  1'b1, 36'hF800, 1'b0, 64'h0, 36'h0,    36'hF800};
    tbl[1]  = '{1'b0, 1'b1, 64'h1,  1'b1, 36'hF808, 1'b1, 64'h1, 36'hF800, 36'hF808};
    tbl[2]  = '{1'b0, 1'b0, 64'h0,  1'b1, 36'hF808, 1'b1, 64'h1, 36'hF800, 36'hF808};
    tbl[3]  = '{1'b0, 1'b1, 64'h2,  1'b1, 36'hF810, 1'b1, 64'h1, 36'hF800, 36'hF810};
    tbl[4]  = '{1'b0, 1'b0, 64'h0,  1'b1, 36'hF810, 1'b1, 64'h1, 36'hF800, 36'hF810};
    tbl[5]  = '{1'b0, 1'b1, 64'h3,  1'b1, 36'hF818, 1'b1, 64'h1, 36'hF800, 36'hF818};
    tbl[6]  = '{1'b0, 1'b0, 64'h0,  1'b1, 36'hF818, 1'b1, 64'h1, 36'hF800, 36'hF818};
    tbl[7]  = '{1'b0, 1'b1, 64'h4,  1'b0, 36'h0,    1'b1, 64'h1, 36'hF800, 36'hF820};
    tbl[8]  = '{1'b0, 1'b1, 64'h99, 1'b0, 36'h0,    1'b1, 64'h1, 36'hF800, 36'hF820};
    tbl[9]  = '{1'b1, 1'b0, 64'h0,  1'b0, 36'h0,    1'b1, 64'h2, 36'hF808, 36'hF820};
    tbl[10] = '{1'b0, 1'b0, 64'h0,  1'b1, 36'hF820, 1'b1, 64'h2, 36'hF808, 36'hF820};
    tbl[11] = '{1'b0, 1'b1, 64'h5,  1'b0, 36'h0,    1'b1, 64'h2, 36'hF808, 36'hF828};

    drive(1'b0, 1'b0, 64'h0, 1'b0, 36'h0);
    rst = 1'b1;
    tick();
    tick();
    expect_out("reset", 1'b0, 36'h0, 1'b0, 64'h0, 36'h0, 36'hF800);
    rst = 1'b0;

    // Fill to four entries, ack ignored while idle, single pop, refill.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rdy, tbl[i].ack, tbl[i].data, 1'b0, 36'h0);
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld,
                 tbl[i].odata, tbl[i].oaddr, tbl[i].ip);
    end

    // Reset in REQ with a coincident ack: request abandoned, fetch restarts.
    drive(1'b1, 1'b0, 64'h0, 1'b0, 36'h0);
    tick();
    expect_out("pop2", 1'b0, 36'h0, 1'b1, 64'h3, 36'hF810, 36'hF828);
    drive(1'b0, 1'b0, 64'h0, 1'b0, 36'h0);
    tick();
    expect_out("req_f828", 1'b1, 36'hF828, 1'b1, 64'h3, 36'hF810, 36'hF828);
    rst = 1'b1;
    drive(1'b0, 1'b1, 64'h77, 1'b1, 36'h4440);
    tick();
    expect_out("rst_in_req", 1'b0, 36'h0, 1'b0, 64'h0, 36'h0, 36'hF800);
    rst = 1'b0;
    drive(1'b0, 1'b0, 64'h0, 1'b0, 36'h0);
    tick();
    expect_out("restart", 1'b1, 36'hF800, 1'b0, 64'h0, 36'h0, 36'hF800);
    drive(1'b0, 1'b1, 64'hA, 1'b0, 36'h0);
    tick();
    expect_out("restart_ack", 1'b1, 36'hF808, 1'b1, 64'hA, 36'hF800, 36'hF808);

    // Redirect without ack: FLUSH holds mem_addr, stale data dropped.
    drive(1'b0, 1'b0, 64'h0, 1'b1, 36'h1234);
    tick();
    expect_out("flush_enter", 1'b1, 36'hF808, 1'b0, 64'h0, 36'h0, 36'h1230);
    drive(1'b0, 1'b0, 64'h0, 1'b0, 36'h0);
    tick();
    expect_out("flush_hold", 1'b1, 36'hF808, 1'b0, 64'h0, 36'h0, 36'h1230);
    drive(1'b0, 1'b1, 64'hDEAD, 1'b0, 36'h0);
    tick();
    expect_out("flush_ack", 1'b0, 36'h0, 1'b0, 64'h0, 36'h0, 36'h1230);
    drive(1'b0, 1'b0, 64'h0, 1'b0, 36'h0);
    tick();
    expect_out("req_1230", 1'b1, 36'h1230, 1'b0, 64'h0, 36'h0, 36'h1230);
    drive(1'b0, 1'b1, 64'hB, 1'b0, 36'h0);
    tick();
    expect_out("ack_1230", 1'b1, 36'h1238, 1'b1, 64'hB, 36'h1230, 36'h1238);

    // Redirect coincident with ack and pop: nothing pushed or popped.
    drive(1'b1, 1'b1, 64'hC, 1'b1, 36'h5000);
    tick();
    expect_out("redir_ack_pop", 1'b0, 36'h0, 1'b0, 64'h0, 36'h0, 36'h5000);
    drive(1'b0, 1'b0, 64'h0, 1'b0, 36'h0);
    tick();
    expect_out("req_5000", 1'b1, 36'h5000, 1'b0, 64'h0, 36'h0, 36'h5000);

    // Second redirect in FLUSH retargets fetch_pc only; then address wrap.
    drive(1'b0, 1'b0, 64'h0, 1'b1, 36'h7777);
    tick();
    expect_out("flush2_enter", 1'b1, 36'h5000, 1'b0, 64'h0, 36'h0, 36'h7770);
    drive(1'b0, 1'b0, 64'h0, 1'b1, 36'hFFFFFFFFF);
    tick();
    expect_out("flush2_redir", 1'b1, 36'h5000, 1'b0, 64'h0, 36'h0, 36'hFFFFFFFF8);
    drive(1'b0, 1'b1, 64'hF, 1'b0, 36'h0);
    tick();
    expect_out("flush2_ack", 1'b0, 36'h0, 1'b0, 64'h0, 36'h0, 36'hFFFFFFFF8);
    drive(1'b0, 1'b0, 64'h0, 1'b0, 36'h0);
    tick();
    expect_out("req_top", 1'b1, 36'hFFFFFFFF8, 1'b0, 64'h0, 36'h0, 36'hFFFFFFFF8);
    drive(1'b0, 1'b1, 64'hE, 1'b0, 36'h0);
    tick();
    expect_out("wrap", 1'b1, 36'h0, 1'b1, 64'hE, 36'hFFFFFFFF8, 36'h0);
    drive(1'b1, 1'b0, 64'h0, 1'b0, 36'h0);
    tick();
    expect_out("drain", 1'b1, 36'h0, 1'b0, 64'h0, 36'h0, 36'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lobster_fetch.md
LOBSTER_FETCH -- requirements
Module: lobster_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 36, byte-address width of fetch and memory addresses.
REQ-002 Parameter FIFO_DEPTH, default 4, number of 64-bit bundle entries in the prefetch buffer; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 36'hF800, fetch address after reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mem_req  output  1  fetch request to instruction memory.
REQ-007 mem_addr  output  ADDR_WIDTH  bundle address of the pending request; 8-byte aligned.
REQ-008 mem_ack  input  1  memory returns mem_data for the pending request this cycle.
REQ-009 mem_data  input  64  fetched instruction bundle.
REQ-010 redirect  input  1  control-flow change; flush and restart fetch.
REQ-011 redirect_pc  input  ADDR_WIDTH  new fetch address; bits [2:0] ignored.
REQ-012 out_valid  output  1  bundle available to the execution manager.
REQ-013 out_ready  input  1  execution manager accepts the bundle.
REQ-014 out_data  output  64  bundle at the FIFO head; the prefix is in bits [1:0].
REQ-015 out_addr  output  ADDR_WIDTH  address of out_data.
REQ-016 ip_out  output  ADDR_WIDTH  current fetch_pc, which is the next address to request.

Function
REQ-017 The FSM SHALL have three states:
- IDLE: no request is outstanding.
- REQ: a request is outstanding and mem_req is 1.
- FLUSH: the outstanding request is stale and mem_req is 1.
REQ-018 mem_req SHALL be 1 exactly in REQ and FLUSH; mem_addr SHALL hold constant from request start until the mem_ack cycle.
REQ-019 IDLE->REQ SHALL occur when (count < FIFO_DEPTH) and redirect is 0; mem_addr is loaded with fetch_pc.
REQ-020 In REQ with mem_ack=1 and redirect=0, the module SHALL:
- push {mem_addr, mem_data} into the FIFO;
- set fetch_pc to mem_addr+8;
- go to REQ if count after push and pop < FIFO_DEPTH, else go to IDLE.
REQ-021 At most one request SHALL be outstanding; mem_ack outside REQ and FLUSH SHALL be ignored.
REQ-022 A push SHALL occur only when count < FIFO_DEPTH, so the FIFO never overflows.
REQ-023 out_valid SHALL equal (count != 0); a pop SHALL occur on out_valid && out_ready.
REQ-024 A simultaneous push and pop SHALL leave count unchanged.
REQ-025 On redirect=1 in any state, the module SHALL:
- empty the FIFO;
- set fetch_pc to {redirect_pc[ADDR_WIDTH-1:3], 3'b000};
- drop any concurrent pop or push.
REQ-026 Redirect in REQ without mem_ack SHALL go to FLUSH; redirect in REQ with mem_ack SHALL go to IDLE and discard the data.
REQ-027 In FLUSH, mem_ack SHALL discard the data and go to IDLE; a further redirect in FLUSH SHALL only update fetch_pc.
REQ-028 out_valid SHALL be 0 in the cycle after any redirect.
REQ-029 fetch_pc+8 SHALL wrap modulo 2^ADDR_WIDTH.
REQ-030 Latency: the first mem_req SHALL be asserted in the first cycle after rst deasserts; mem_ack to out_valid SHALL take 1 cycle.

Reset
REQ-031 rst SHALL set state=IDLE, fetch_pc=RESET_PC and count=0; mem_req=0, out_valid=0, ip_out=RESET_PC.
REQ-032 rst SHALL take priority over redirect and mem_ack; an outstanding request is abandoned, and a mem_ack in the rst cycle is ignored.
REQ-033 out_data and out_addr are don't-care while out_valid=0.

Structure
REQ-034 Package lobster_pkg SHALL hold:
- the fetch state enum (IDLE, REQ, FLUSH);
- BUNDLE_BYTES=8;
- the RESET_PC default.
REQ-035 The buffer SHALL be a sub-module lobster_fifo: a synchronous FIFO with push, pop, flush and count, data width ADDR_WIDTH+64.

Verification
REQ-036 Reset, then mem_ack on the second cycle of each request with data 64'h1..64'h4, out_ready=0 -> requests at F800, F808, F810, F818; mem_req=0 once count=4.
REQ-037 From the full state, pulse out_ready for one cycle -> out_data=64'h1 and out_addr=F800 popped, next mem_addr=F820.
REQ-038 Redirect to 36'h1234 while in REQ without ack -> FLUSH; mem_addr unchanged until ack; that data is dropped; the next request goes to 36'h1230.
REQ-039 Redirect coincident with mem_ack and out_ready -> FIFO empty, nothing pushed or popped, out_valid=0 the next cycle.
REQ-040 Redirect to 36'hFFFFFFFF8 -> bundle at FFFFFFFF8, next request at 36'h0.
REQ-041 Assert rst for one cycle while in REQ -> mem_req=0, count=0, ip_out=F800, fetch restarts normally.
